s_serializer_piso: RTL and testbench

- Parallel-in/serial-out stage sitting directly upstream of the 1010 sequence detector; drives its serial input x one bit per clock.
- Accepts WIDTH-bit words over a valid/ready handshake; streams back-to-back words with no idle gap via a one-word holding buffer.
- Outputs a bit-valid qualifier and frame-start marker so downstream logic can align matches to word boundaries.

---
 rtl/s_serializer_piso_pkg.sv | 12 +
 rtl/s_serializer_piso.sv | 123 ++++++++++++
 tb/tb_s_serializer_piso.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/s_serializer_piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out stage feeding the 1010 detector.
package s_serializer_piso_pkg;

   typedef enum logic {
      StIdle,
      StShift
   } state_t;

   // Default word width, shared so detector-side benches size stimulus consistently.
   localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/s_serializer_piso.sv
// Serializes WIDTH-bit words onto x_out, one bit per clock, with a one-word holding buffer
// so back-to-back words stream without an idle gap.
module s_serializer_piso
   import s_serializer_piso_pkg::*;
#(
   parameter int unsigned WIDTH     = DefaultWidth,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x_out,
   output logic             x_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int unsigned    CntW    = $clog2(WIDTH);
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             buf_full_q, buf_full_d;
   logic             ready_q;
   logic             x_out_q, x_out_d;
   logic             x_valid_q, x_valid_d;
   logic             frame_q, frame_d;
   logic             busy_q, busy_d;

   logic             accept;
   logic             cur_bit;
   logic [WIDTH-1:0] shifted;

   assign accept  = din_valid && ready_q;
   assign cur_bit = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
   assign shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sreg_d     = sreg_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      x_out_d    = IDLE_BIT;
      x_valid_d  = 1'b0;
      frame_d    = 1'b0;
      busy_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               sreg_d  = din;
               cnt_d   = '0;
               state_d = StShift;
            end
         end
         StShift: begin
            x_out_d   = cur_bit;
            x_valid_d = 1'b1;
            frame_d   = (cnt_q == '0);
            busy_d    = 1'b1;
            if (cnt_q == CntLast) begin
               cnt_d = '0;
               // Buffered word has priority; ready is low then, so din cannot also be taken.
               if (buf_full_q) begin
                  sreg_d     = buf_q;
                  buf_full_d = 1'b0;
               end else if (accept) begin
                  sreg_d = din;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d  = cnt_q + 1'b1;
               sreg_d = shifted;
               if (accept) begin
                  buf_d      = din;
                  buf_full_d = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         sreg_q     <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         ready_q    <= 1'b0;
         x_out_q    <= IDLE_BIT;
         x_valid_q  <= 1'b0;
         frame_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sreg_q     <= sreg_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         ready_q    <= !buf_full_d;
         x_out_q    <= x_out_d;
         x_valid_q  <= x_valid_d;
         frame_q    <= frame_d;
         busy_q     <= busy_d;
      end
   end

   assign din_ready   = ready_q;
   assign x_out       = x_out_q;
   assign x_valid     = x_valid_q;
   assign frame_start = frame_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_s_serializer_piso.sv
// Bench for s_serializer_piso: an MSB-first/IDLE_BIT=0 and an LSB-first/IDLE_BIT=1 instance
// share one stimulus stream and are checked every cycle against a bit-queue model.
module tb_s_serializer_piso;
   import s_serializer_piso_pkg::*;

   localparam int unsigned W = DefaultWidth;

   logic         clk;
   logic         reset_n;
   logic [W-1:0] din;
   logic         din_valid;

   logic m_rdy, m_x, m_v, m_fs, m_busy;
   logic l_rdy, l_x, l_v, l_fs, l_busy;

   int total = 0;
   int bad   = 0;

   s_serializer_piso #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
      .clk        (clk),
      .reset_n    (reset_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (m_rdy),
      .x_out      (m_x),
      .x_valid    (m_v),
      .frame_start(m_fs),
      .busy       (m_busy)
   );

   s_serializer_piso #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
      .clk        (clk),
      .reset_n    (reset_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (l_rdy),
      .x_out      (l_x),
      .x_valid    (l_v),
      .frame_start(l_fs),
      .busy       (l_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40)
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: every accepted word appends its bits to a queue; each clock edge emits the head
   // of the queue (before that edge's accept is appended). More than one word's worth of
   // queued bits means the holding buffer is occupied, so ready drops.
   logic bq_m[$];
   logic bq_l[$];
   logic fq[$];
   logic e_x_m = 1'b0, e_x_l = 1'b1, e_v = 1'b0, e_fs = 1'b0, e_rdy = 1'b0;
   logic acc;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bq_m.delete();
         bq_l.delete();
         fq.delete();
         e_x_m = 1'b0;
         e_x_l = 1'b1;
         e_v   = 1'b0;
         e_fs  = 1'b0;
         e_rdy = 1'b0;
      end else begin
         acc = din_valid && e_rdy;
         if (bq_m.size() > 0) begin
            e_x_m = bq_m.pop_front();
            e_x_l = bq_l.pop_front();
            e_fs  = fq.pop_front();
            e_v   = 1'b1;
         end else begin
            e_x_m = 1'b0;
            e_x_l = 1'b1;
            e_fs  = 1'b0;
            e_v   = 1'b0;
         end
         if (acc) begin
            for (int i = 0; i < int'(W); i++) begin
               bq_m.push_back(din[W-1-i]);
               bq_l.push_back(din[i]);
               fq.push_back(i == 0);
            end
         end
         e_rdy = (bq_m.size() <= W);
      end
   end

   always @(negedge clk) begin
      chk("msb_x_out", {31'd0, m_x}, {31'd0, e_x_m});
      chk("msb_x_valid", {31'd0, m_v}, {31'd0, e_v});
      chk("msb_frame_start", {31'd0, m_fs}, {31'd0, e_fs});
      chk("msb_busy", {31'd0, m_busy}, {31'd0, e_v});
      chk("msb_din_ready", {31'd0, m_rdy}, {31'd0, e_rdy});
      chk("lsb_x_out", {31'd0, l_x}, {31'd0, e_x_l});
      chk("lsb_x_valid", {31'd0, l_v}, {31'd0, e_v});
      chk("lsb_frame_start", {31'd0, l_fs}, {31'd0, e_fs});
      chk("lsb_busy", {31'd0, l_busy}, {31'd0, e_v});
      chk("lsb_din_ready", {31'd0, l_rdy}, {31'd0, e_rdy});
   end

   // Sends one word into an idle DUT and records cycles 1..10 after the accepting edge.
   task automatic send_one(input logic [W-1:0] w, output logic [9:0] mseq,
                           output logic [9:0] lseq, output logic [9:0] vseq,
                           output logic [9:0] fseq);
      din       = w;
      din_valid = 1'b1;
      @(posedge clk);
      #1 din_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         @(negedge clk);
         mseq[k] = m_x;
         lseq[k] = l_x;
         vseq[k] = m_v;
         fseq[k] = m_fs;
      end
   endtask

   logic [9:0]   mseq, lseq, vseq, fseq;
   logic [W-1:0] mbyte, lbyte;
   logic [W-1:0] words [3];
   int           pct_tab [6];

   initial begin
      reset_n   = 1'b0;
      din       = '0;
      din_valid = 1'b0;
      #32 reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_release", {31'd0, m_rdy}, 32'd1);

      // Idle level: nothing presented for 20 cycles.
      repeat (20) @(posedge clk);
      #1;

      // Single word 8'hA5.
      send_one(8'hA5, mseq, lseq, vseq, fseq);
      for (int k = 0; k < 8; k++) begin
         mbyte = {mbyte[W-2:0], mseq[k]};
         lbyte[k] = lseq[k];
      end
      chk("lit_a5_msb_bits", {24'd0, mbyte}, 32'h0000_00A5);
      chk("lit_a5_lsb_bits", {24'd0, lbyte}, 32'h0000_00A5);
      chk("lit_a5_valid", {22'd0, vseq}, 32'h0000_00FF);
      chk("lit_a5_frame", {22'd0, fseq}, 32'h0000_0001);
      chk("lit_a5_msb_idle", {30'd0, mseq[9:8]}, 32'd0);
      chk("lit_a5_lsb_idle", {30'd0, lseq[9:8]}, 32'd3);

      // LSB-first 8'h01: a single 1 then seven 0s.
      send_one(8'h01, mseq, lseq, vseq, fseq);
      chk("lit_01_lsb_bits", {24'd0, lseq[7:0]}, 32'h0000_0001);
      chk("lit_01_msb_bits", {24'd0, mseq[7:0]}, 32'h0000_0080);

      // Reset mid-word with the buffer full.
      din       = 8'hFF;
      din_valid = 1'b1;
      @(posedge clk);
      #1 din = 8'h3C;
      @(posedge clk);
      #1 din_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_x_valid", {31'd0, m_v}, 32'd0);
      chk("rst_busy", {31'd0, m_busy}, 32'd0);
      chk("rst_msb_idle", {31'd0, m_x}, 32'd0);
      chk("rst_lsb_idle", {31'd0, l_x}, 32'd1);
      chk("rst_ready", {31'd0, m_rdy}, 32'd0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_ready_release", {31'd0, m_rdy}, 32'd1);
      repeat (12) @(posedge clk);
      #1;

      // Backpressure: three words with din_valid held, advanced on each model accept.
      words[0] = 8'h0A;
      words[1] = 8'h0A;
      words[2] = 8'hC3;
      for (int k = 0; k < 3; ) begin
         logic was;
         din       = words[k];
         din_valid = 1'b1;
         was       = e_rdy;
         @(posedge clk);
         #1;
         if (was) k++;
      end
      din_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;

      // Randomized traffic with varying offered load and occasional async resets.
      pct_tab[0] = 100;
      pct_tab[1] = 70;
      pct_tab[2] = 30;
      pct_tab[3] = 95;
      pct_tab[4] = 5;
      pct_tab[5] = 100;
      for (int n = 0; n < 3000; n++) begin
         din       = W'($urandom);
         din_valid = ($urandom_range(0, 99) < pct_tab[(n / 250) % 6]);
         @(posedge clk);
         #1;
         if ($urandom_range(0, 399) == 0) begin
            #2 reset_n = 1'b0;
            @(negedge clk);
            #2 reset_n = 1'b1;
         end
      end
      din_valid = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
